multi_sched: RTL and testbench

MULTI_SCHED -- requirements
Module: multi_sched

---
 rtl/multi_sched.sv | 190 +++++++++++++++++++
 tb/tb_multi_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sched.sv
// multi_sched: round-robin front end that lets two requesters share one
// bit-serial multiplier.
//
// A winning requester's operands are latched into shift registers and sent
// LSB first on M_A/M_B while M_VALID is high. The multiplier returns the
// product LSB first on M_O, starting LAT cycles after the first operand bit.
// When the last product bit is in, the owner gets a one-cycle DONE pulse and
// RES/RES_ID carry the product until the next completion.
//
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous reset, active low
//   REQ0, REQ1   level requests
//   A0,B0,A1,B1  operands, W bits each
//   DONE0/DONE1  one-cycle completion pulse to the owner
//   RES, RES_ID  last product (2W bits) and its owner
//   M_VALID      operand bit valid to the multiplier
//   M_A, M_B     serial operand bits, LSB first
//   M_O          serial product bit from the multiplier, LSB first

module multi_sched #(
  parameter int W   = 4,
  parameter int LAT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ0,
  input  logic           REQ1,
  input  logic [W-1:0]   A0,
  input  logic [W-1:0]   B0,
  input  logic [W-1:0]   A1,
  input  logic [W-1:0]   B1,
  output logic           DONE0,
  output logic           DONE1,
  output logic [2*W-1:0] RES,
  output logic           RES_ID,
  output logic           M_VALID,
  output logic           M_A,
  output logic           M_B,
  input  logic           M_O
);

  localparam int P    = 2 * W;
  localparam int NCYC = LAT + P;
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [CW-1:0] LAST_SEND = CW'(W - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(NCYC - 1);
  localparam logic [CW-1:0] FIRST_SMP = CW'(LAT);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    COLLECT,
    DONE
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [P-1:0]   prod_q;
  logic           own_q;
  logic           ptr_q;
  logic           m_valid_q;
  logic           m_a_q;
  logic           m_b_q;
  logic           done0_q;
  logic           done1_q;
  logic [P-1:0]   res_q;
  logic           res_id_q;

  logic           gnt_d;
  logic [W-1:0]   op_a_d;
  logic [W-1:0]   op_b_d;
  logic           smp_d;
  logic [P-1:0]   prod_d;

  // ptr_q holds the last granted requester; a tie goes to the other one.
  // A lone request simply wins.
  always_comb begin
    gnt_d = REQ1;
    if (REQ0 && REQ1) begin
      gnt_d = ~ptr_q;
    end
  end

  always_comb begin
    op_a_d = gnt_d ? A1 : A0;
    op_b_d = gnt_d ? B1 : B0;
  end

  // Product bits arrive LSB first from CNT=LAT on; shifting in at the top
  // leaves bit 0 at the bottom after exactly 2W samples.
  always_comb begin
    smp_d  = (cnt_q >= FIRST_SMP);
    prod_d = prod_q;
    if (smp_d) begin
      prod_d = {M_O, prod_q[P-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      own_q     <= 1'b0;
      ptr_q     <= 1'b1;
      m_valid_q <= 1'b0;
      m_a_q     <= 1'b0;
      m_b_q     <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      res_q     <= '0;
      res_id_q  <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          m_valid_q <= 1'b0;
          m_a_q     <= 1'b0;
          m_b_q     <= 1'b0;
          if (REQ0 || REQ1) begin
            own_q     <= gnt_d;
            ptr_q     <= gnt_d;
            cnt_q     <= '0;
            prod_q    <= '0;
            // Bit 0 goes out right away; the rest wait in the shifters.
            m_valid_q <= 1'b1;
            m_a_q     <= op_a_d[0];
            m_b_q     <= op_b_d[0];
            a_q       <= op_a_d >> 1;
            b_q       <= op_b_d >> 1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          cnt_q  <= cnt_q + 1'b1;
          prod_q <= prod_d;
          if (cnt_q == LAST_SEND) begin
            m_valid_q <= 1'b0;
            m_a_q     <= 1'b0;
            m_b_q     <= 1'b0;
            state_q   <= COLLECT;
          end else begin
            m_a_q <= a_q[0];
            m_b_q <= b_q[0];
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
          end
        end
        COLLECT: begin
          m_valid_q <= 1'b0;
          m_a_q     <= 1'b0;
          m_b_q     <= 1'b0;
          prod_q    <= prod_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done0_q  <= ~own_q;
          done1_q  <= own_q;
          res_q    <= prod_q;
          res_id_q <= own_q;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign RES     = res_q;
  assign RES_ID  = res_id_q;
  assign M_VALID = m_valid_q;
  assign M_A     = m_a_q;
  assign M_B     = m_b_q;

endmodule

// File: tb/tb_multi_sched.sv
// tb_multi_sched: directed and random checks of multi_sched against a
// cycle-timed transaction model and a behavioural serial multiplier.

module tb_multi_sched;

  localparam int W  = 4;
  localparam int LAT = 1;
  localparam int P  = 2 * W;
  localparam int NC = LAT + P;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         REQ0 = 1'b0;
  logic         REQ1 = 1'b0;
  logic [W-1:0] A0 = '0;
  logic [W-1:0] B0 = '0;
  logic [W-1:0] A1 = '0;
  logic [W-1:0] B1 = '0;
  logic         DONE0;
  logic         DONE1;
  logic [P-1:0] RES;
  logic         RES_ID;
  logic         M_VALID;
  logic         M_A;
  logic         M_B;
  logic         M_O = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multi_sched #(.W(W), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .DONE0(DONE0), .DONE1(DONE1),
    .RES(RES), .RES_ID(RES_ID),
    .M_VALID(M_VALID), .M_A(M_A), .M_B(M_B),
    .M_O(M_O)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a granted operation occupies NC cycles of
  // send/collect plus one DONE cycle; completion is visible right after.
  int           ph = -1;
  bit           ptr = 1'b1;
  bit           own = 1'b0;
  logic [P-1:0] oa = '0;
  logic [P-1:0] ob = '0;
  bit           e_d0 = 1'b0;
  bit           e_d1 = 1'b0;
  logic [P-1:0] e_res = '0;
  bit           e_id = 1'b0;
  bit           mdl_ok = 1'b0;

  always @(posedge CLK) begin
    if (!RST) begin
      ph = -1;
      ptr = 1'b1;
      e_d0 = 1'b0;
      e_d1 = 1'b0;
      e_res = '0;
      e_id = 1'b0;
      mdl_ok = 1'b1;
    end else begin
      e_d0 = 1'b0;
      e_d1 = 1'b0;
      if (ph < 0) begin
        if (REQ0 || REQ1) begin
          own = (REQ0 && REQ1) ? !ptr : REQ1;
          ptr = own;
          oa = {{W{1'b0}}, (own ? A1 : A0)};
          ob = {{W{1'b0}}, (own ? B1 : B0)};
          ph = 0;
        end
      end else begin
        ph++;
        if (ph == NC + 1) begin
          if (own) e_d1 = 1'b1;
          else e_d0 = 1'b1;
          e_res = oa * ob;
          e_id = own;
          ph = -1;
        end
      end
    end
  end

  // Compare process, mid-cycle.
  always @(negedge CLK) begin
    bit ev;
    bit ea;
    bit eb;
    if (mdl_ok) begin
      ev = (ph >= 0) && (ph < W);
      ea = ev ? oa[ph] : 1'b0;
      eb = ev ? ob[ph] : 1'b0;
      chk("DONE0", DONE0, e_d0);
      chk("DONE1", DONE1, e_d1);
      chk("RES", RES, e_res);
      chk("RES_ID", RES_ID, e_id);
      chk("M_VALID", M_VALID, ev);
      chk("M_A", M_A, ea);
      chk("M_B", M_B, eb);
    end
  end

  // Serial multiplier: product bit j appears LAT cycles after operand
  // bit j; outside the result window M_O carries noise.
  bit           mact = 1'b0;
  int           mk = 0;
  logic [P-1:0] ma = '0;
  logic [P-1:0] mb = '0;
  logic [P-1:0] mp;

  always @(negedge CLK) begin
    if (!RST) mact = 1'b0;
    else if (!mact && M_VALID) begin
      mact = 1'b1;
      mk = 0;
      ma = '0;
      mb = '0;
    end
    if (mact && RST) begin
      if (M_VALID && mk < W) begin
        ma[mk] = M_A;
        mb[mk] = M_B;
      end
      mp = ma * mb;
      if (mk >= LAT) M_O = mp[mk-LAT];
      else M_O = 1'($urandom);
      mk++;
      if (mk == NC) mact = 1'b0;
    end else begin
      M_O = 1'($urandom);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges until DONE of 'who'; also counts all-ones operand cycles
  // and any DONE pulse for the other requester.
  task automatic wait_done(input bit who, output int n, output int nv,
                           output int other);
    bit hit;
    n = 0;
    nv = 0;
    other = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      tick();
      n++;
      if (M_VALID && M_A && M_B) nv++;
      if (who ? DONE0 : DONE1) other++;
      if (who ? DONE1 : DONE0) hit = 1'b1;
    end
    if (!hit) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_any(output int who);
    int n;
    n = 0;
    who = -1;
    while (who < 0 && n < 100) begin
      tick();
      n++;
      if (DONE0) who = 0;
      if (DONE1) who = 1;
    end
    if (who < 0) chk("any_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int nv;
    int o;
    int who;
    int seq[4];

    RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("rst_done0", DONE0, 0);
    chk("rst_res", RES, 0);
    chk("rst_valid", M_VALID, 0);

    // Single operation, all ones.
    REQ0 = 1'b1; A0 = 4'd15; B0 = 4'd15;
    wait_done(1'b0, n, nv, o);
    REQ0 = 1'b0;
    chk("t1_latency", n - 1, 10);
    chk("t1_valid_ones", nv, 4);
    chk("t1_res", RES, 225);
    chk("t1_id", RES_ID, 0);

    // Simultaneous requests after reset: requester 0 first.
    RST = 1'b0;
    tick();
    RST = 1'b1;
    REQ0 = 1'b1; A0 = 4'd3; B0 = 4'd5;
    REQ1 = 1'b1; A1 = 4'd7; B1 = 4'd9;
    wait_done(1'b0, n, nv, o);
    REQ0 = 1'b0;
    chk("t2_res0", RES, 15);
    chk("t2_id0", RES_ID, 0);
    wait_done(1'b1, n, nv, o);
    REQ1 = 1'b0;
    chk("t2_spacing", n, 11);
    chk("t2_res1", RES, 63);
    chk("t2_id1", RES_ID, 1);

    // Alternation with both held.
    tick();
    REQ1 = 1'b1; A1 = 4'd2; B1 = 4'd3;
    tick();
    REQ0 = 1'b1; A0 = 4'd5; B0 = 4'd6;
    for (int i = 0; i < 4; i++) begin
      wait_any(who);
      seq[i] = who;
      chk("t3_res", RES, (who == 1) ? 6 : 30);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    chk("t3_g0", seq[0], 1);
    chk("t3_g1", seq[1], 0);
    chk("t3_g2", seq[2], 1);
    chk("t3_g3", seq[3], 0);

    // Reset during COLLECT, then a fresh operation.
    tick();
    REQ0 = 1'b1; A0 = 4'd13; B0 = 4'd11;
    tick();
    repeat (5) tick();
    RST = 1'b0;
    tick();
    chk("t4_valid", M_VALID, 0);
    chk("t4_res", RES, 0);
    chk("t4_done0", DONE0, 0);
    RST = 1'b1;
    wait_done(1'b0, n, nv, o);
    REQ0 = 1'b0;
    chk("t4_latency", n - 1, 10);
    chk("t4_res2", RES, 143);

    // Zero product, then requester 1.
    tick();
    REQ0 = 1'b1; A0 = 4'd0; B0 = 4'd15;
    wait_done(1'b0, n, nv, o);
    REQ0 = 1'b0;
    chk("t5_res0", RES, 0);
    chk("t5_no_done1", o, 0);
    REQ1 = 1'b1; A1 = 4'd15; B1 = 4'd1;
    wait_done(1'b1, n, nv, o);
    REQ1 = 1'b0;
    chk("t5_res1", RES, 15);
    chk("t5_id1", RES_ID, 1);

    // Request dropped two cycles into SEND.
    tick();
    REQ0 = 1'b1; A0 = 4'd9; B0 = 4'd6;
    tick();
    tick();
    tick();
    REQ0 = 1'b0;
    wait_done(1'b0, n, nv, o);
    chk("t6_wait", n, 8);
    chk("t6_res", RES, 54);
    chk("t6_id", RES_ID, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      #2;
      RST = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      if (!REQ0) begin
        if ($urandom_range(3) == 0) begin
          REQ0 = 1'b1;
          A0 = W'($urandom);
          B0 = W'($urandom);
        end
      end else if (DONE0) begin
        if ($urandom_range(1) == 0) REQ0 = 1'b0;
      end else if ($urandom_range(31) == 0) begin
        REQ0 = 1'b0;
      end
      if (!REQ1) begin
        if ($urandom_range(3) == 0) begin
          REQ1 = 1'b1;
          A1 = W'($urandom);
          B1 = W'($urandom);
        end
      end else if (DONE1) begin
        if ($urandom_range(1) == 0) REQ1 = 1'b0;
      end else if ($urandom_range(31) == 0) begin
        REQ1 = 1'b0;
      end
    end
    RST = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
